// File: rtl/bcd_ascii_streamer.sv
// Streams a packed BCD value to a byte sink as ASCII, with optional leading-zero
// suppression and CR/LF terminator; one byte per cycle when the sink is always ready.
module bcd_ascii_streamer #(
    parameter int NUM_DIGITS     = 10,
    parameter bit APPEND_CRLF    = 1'b1,
    parameter bit SUPPRESS_ZEROS = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIGIT = 2'd1;
    localparam logic [1:0] ST_CR    = 2'd2;
    localparam logic [1:0] ST_LF    = 2'd3;

    logic [1:0]              state_q,    state_d;
    logic [4*NUM_DIGITS-1:0] digits_q,   digits_d;
    logic [IDX_W-1:0]        idx_q,      idx_d;
    logic [7:0]              tx_data_q,  tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q,     busy_d;
    logic                    done_q,     done_d;

    logic [IDX_W-1:0]        first_idx;
    logic                    hs;
    logic                    finish;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [3:0] nibble(input logic [4*NUM_DIGITS-1:0] v, input int k);
        return v[4*NUM_DIGITS-1-4*k -: 4];
    endfunction

    // Scan from the LSD upward so the most significant non-zero digit wins;
    // invalid nibbles count as non-zero. All-zero input leaves a single '0'.
    always_comb begin
        if (!SUPPRESS_ZEROS) begin
            first_idx = '0;
        end else begin
            first_idx = LAST_IDX;
            for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
                if (nibble(bcd_in, k) != 4'h0) first_idx = IDX_W'(k);
            end
        end
    end

    assign hs = tx_valid_q && tx_ready;

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        finish     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    digits_d   = bcd_in;
                    idx_d      = first_idx;
                    state_d    = ST_DIGIT;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    tx_data_d  = to_ascii(nibble(bcd_in, int'(first_idx)));
                end
            end
            ST_DIGIT: begin
                if (hs) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d     = idx_q + IDX_W'(1);
                        tx_data_d = to_ascii(nibble(digits_q, int'(idx_q) + 1));
                    end else if (APPEND_CRLF) begin
                        state_d   = ST_CR;
                        tx_data_d = 8'h0D;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            ST_CR: begin
                if (hs) begin
                    state_d   = ST_LF;
                    tx_data_d = 8'h0A;
                end
            end
            default: begin
                if (hs) finish = 1'b1;
            end
        endcase

        // tx_data deliberately keeps the last byte after the stream ends.
        if (finish) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            digits_q   <= '0;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule
